// File: rtl/cas_recorder.sv
// cas_recorder
//   Decodes the MSX cassette-output bit (1200-baud FSK on PPI C5) into bytes
//   and writes them into the tape buffer in .CAS layout: every header tone
//   becomes an 8-byte aligned marker (1F A6 DE BA CC 13 7D 74), followed by
//   the data bytes of that block.
//
// Ports
//   clk            system clock (clk_sys)
//   reset          synchronous, active-high
//   ce_5m3         ~5.369 MHz tick enable, timebase for cycle measurement
//   motor          cassette motor; decoding runs only while high
//   cas_in         MSX cassette-output level (asynchronous)
//   rewind         returns the write address to 0 and clears status
//   ram_a          buffer byte address of the current/next write
//   ram_do         buffer write data
//   ram_wr         one-clk write strobe
//   buff_mem_ready buffer can accept a write
//   rec_len        bytes written so far (same as ram_a)
//   frame_err      sticky: a bit-level decode error occurred
//   overflow       sticky: a byte was dropped because the FIFO was full

module cas_recorder #(
    parameter int SHORT_MAX = 3356,
    parameter int GAP_TICKS = 8192,
    parameter int HDR_MIN   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_5m3,
    input  logic        motor,
    input  logic        cas_in,
    input  logic        rewind,
    output logic [26:0] ram_a,
    output logic [7:0]  ram_do,
    output logic        ram_wr,
    input  logic        buff_mem_ready,
    output logic [26:0] rec_len,
    output logic        frame_err,
    output logic        overflow
);

    localparam logic [13:0] SHORT_LIM = 14'(SHORT_MAX);
    localparam logic [13:0] GAP_LIM   = 14'(GAP_TICKS);
    localparam logic [15:0] HDR_LIM   = 16'(HDR_MIN);

    typedef enum logic [2:0] {D_IDLE, D_HDR, D_DATA, D_STOP, D_START} dec_state_t;
    typedef enum logic [1:0] {W_IDLE, W_PAD, W_MARK, W_DATA} wr_state_t;

    // Rewind behaves exactly like reset, every clock it is held.
    logic clear;
    assign clear = reset | rewind;

    logic cas_s1, cas_s2, cas_prev;
    logic rise;
    logic [13:0] cyc_cnt;
    logic is_short;
    logic gap;

    dec_state_t dec_state, dec_state_n;
    logic [15:0] hdr_cnt, hdr_cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic        half_one, half_one_n;
    logic [7:0]  shift_reg, shift_n;
    logic [1:0]  stop_cnt, stop_cnt_n;
    logic        bit_done, bit_val;
    logic        push, hdr_req, err_set;

    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] fifo_cnt;
    logic       fifo_full, fifo_empty;
    logic       do_push, do_pop, pop;

    logic       hdr_pend, hdr_serve;
    wr_state_t  w_state, w_state_n;
    logic [2:0] mark_idx, mark_idx_n;
    logic       issue;
    logic [7:0] wr_byte;
    logic [7:0] mark_byte;

    // Two-flop synchronizer; the previous level used for edge detection only
    // advances on ticks so a rise is seen exactly once, on a ce_5m3 tick.
    always_ff @(posedge clk) begin
        if (clear) begin
            cas_s1   <= 1'b0;
            cas_s2   <= 1'b0;
            cas_prev <= 1'b0;
        end else begin
            cas_s1 <= cas_in;
            cas_s2 <= cas_s1;
            if (ce_5m3) begin
                cas_prev <= cas_s2;
            end
        end
    end

    assign rise = ce_5m3 & cas_s2 & ~cas_prev;

    // Cycle timer: ticks since the last rising edge, saturating at the gap
    // length so a long silence stays recognisable.
    always_ff @(posedge clk) begin
        if (clear) begin
            cyc_cnt <= '0;
        end else if (ce_5m3) begin
            if (rise) begin
                cyc_cnt <= '0;
            end else if (cyc_cnt != GAP_LIM) begin
                cyc_cnt <= cyc_cnt + 14'd1;
            end
        end
    end

    assign is_short = (cyc_cnt < SHORT_LIM);
    assign gap      = (cyc_cnt == GAP_LIM);

    // Decoder state register.
    always_ff @(posedge clk) begin
        if (clear) begin
            dec_state <= D_IDLE;
            hdr_cnt   <= '0;
            bit_idx   <= '0;
            half_one  <= 1'b0;
            shift_reg <= '0;
            stop_cnt  <= '0;
        end else begin
            dec_state <= dec_state_n;
            hdr_cnt   <= hdr_cnt_n;
            bit_idx   <= bit_idx_n;
            half_one  <= half_one_n;
            shift_reg <= shift_n;
            stop_cnt  <= stop_cnt_n;
        end
    end

    // Decoder next state. Every rising edge closes one cycle, which is then
    // classified as short (a "1" half-bit / header tone) or long (a "0" bit
    // or a start bit). A partial byte abandoned by silence or motor-off is
    // simply forgotten.
    always_comb begin
        dec_state_n = dec_state;
        hdr_cnt_n   = hdr_cnt;
        bit_idx_n   = bit_idx;
        half_one_n  = half_one;
        shift_n     = shift_reg;
        stop_cnt_n  = stop_cnt;
        bit_done    = 1'b0;
        bit_val     = 1'b0;
        push        = 1'b0;
        hdr_req     = 1'b0;
        err_set     = 1'b0;

        if (!motor) begin
            dec_state_n = D_IDLE;
            half_one_n  = 1'b0;
        end else if (rise) begin
            case (dec_state)
                D_IDLE: begin
                    dec_state_n = D_HDR;
                    hdr_cnt_n   = '0;
                end
                D_HDR: begin
                    if (is_short) begin
                        if (hdr_cnt != 16'hFFFF) begin
                            hdr_cnt_n = hdr_cnt + 16'd1;
                        end
                    end else if (hdr_cnt >= HDR_LIM) begin
                        hdr_req     = 1'b1;
                        dec_state_n = D_DATA;
                        bit_idx_n   = '0;
                        half_one_n  = 1'b0;
                    end else begin
                        hdr_cnt_n = '0;
                    end
                end
                D_DATA: begin
                    if (is_short) begin
                        if (!half_one) begin
                            half_one_n = 1'b1;
                        end else begin
                            half_one_n = 1'b0;
                            bit_done   = 1'b1;
                            bit_val    = 1'b1;
                        end
                    end else if (half_one) begin
                        err_set     = 1'b1;
                        dec_state_n = D_HDR;
                        hdr_cnt_n   = '0;
                        half_one_n  = 1'b0;
                    end else begin
                        bit_done = 1'b1;
                        bit_val  = 1'b0;
                    end
                    // LSB arrives first, so shift in from the top.
                    if (bit_done) begin
                        shift_n = {bit_val, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            dec_state_n = D_STOP;
                            stop_cnt_n  = '0;
                        end else begin
                            bit_idx_n = bit_idx + 3'd1;
                        end
                    end
                end
                D_STOP: begin
                    if (is_short) begin
                        if (stop_cnt == 2'd3) begin
                            push        = 1'b1;
                            dec_state_n = D_START;
                        end else begin
                            stop_cnt_n = stop_cnt + 2'd1;
                        end
                    end else begin
                        // Broken stop bits: keep the byte, resync on this start bit.
                        err_set     = 1'b1;
                        push        = 1'b1;
                        dec_state_n = D_DATA;
                        bit_idx_n   = '0;
                        half_one_n  = 1'b0;
                    end
                end
                D_START: begin
                    if (is_short) begin
                        dec_state_n = D_HDR;
                        hdr_cnt_n   = 16'd1;
                    end else begin
                        dec_state_n = D_DATA;
                        bit_idx_n   = '0;
                        half_one_n  = 1'b0;
                    end
                end
                default: dec_state_n = D_IDLE;
            endcase
        end else if (gap) begin
            dec_state_n = D_IDLE;
            half_one_n  = 1'b0;
        end
    end

    // A push into a full FIFO still succeeds when the writer pops that clock.
    assign fifo_full  = (fifo_cnt == 3'd4);
    assign fifo_empty = (fifo_cnt == 3'd0);
    assign do_push    = push & (~fifo_full | pop);
    assign do_pop     = pop & ~fifo_empty;

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= shift_reg;
        end
    end

    // FIFO pointers and the sticky status flags.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            fifo_cnt <= fifo_cnt + {2'b00, do_push} - {2'b00, do_pop};
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
            if (err_set) begin
                frame_err <= 1'b1;
            end
        end
    end

    // Header requests are one-clk pulses; hold them until the writer starts
    // the marker. A new request in the serving clock wins.
    always_ff @(posedge clk) begin
        if (clear) begin
            hdr_pend <= 1'b0;
        end else if (hdr_req) begin
            hdr_pend <= 1'b1;
        end else if (hdr_serve) begin
            hdr_pend <= 1'b0;
        end
    end

    always_comb begin
        case (mark_idx)
            3'd0:    mark_byte = 8'h1F;
            3'd1:    mark_byte = 8'hA6;
            3'd2:    mark_byte = 8'hDE;
            3'd3:    mark_byte = 8'hBA;
            3'd4:    mark_byte = 8'hCC;
            3'd5:    mark_byte = 8'h13;
            3'd6:    mark_byte = 8'h7D;
            default: mark_byte = 8'h74;
        endcase
    end

    // Writer state register.
    always_ff @(posedge clk) begin
        if (clear) begin
            w_state  <= W_IDLE;
            mark_idx <= '0;
        end else begin
            w_state  <= w_state_n;
            mark_idx <= mark_idx_n;
        end
    end

    // Writer next state. It only acts while no strobe is on the bus: that
    // guarantees ram_a has already advanced past the previous write (so the
    // alignment test sees the true address) and spaces strobes at least two
    // clocks apart.
    always_comb begin
        w_state_n  = w_state;
        mark_idx_n = mark_idx;
        issue      = 1'b0;
        wr_byte    = 8'h00;
        pop        = 1'b0;
        hdr_serve  = 1'b0;

        if (!ram_wr) begin
            case (w_state)
                W_IDLE: begin
                    if (hdr_pend) begin
                        hdr_serve = 1'b1;
                        if (ram_a[2:0] != 3'd0) begin
                            w_state_n = W_PAD;
                        end else begin
                            w_state_n  = W_MARK;
                            mark_idx_n = '0;
                        end
                    end else if (!fifo_empty) begin
                        w_state_n = W_DATA;
                    end
                end
                W_PAD: begin
                    if (ram_a[2:0] == 3'd0) begin
                        w_state_n  = W_MARK;
                        mark_idx_n = '0;
                    end else if (buff_mem_ready) begin
                        issue   = 1'b1;
                        wr_byte = 8'h00;
                    end
                end
                W_MARK: begin
                    if (buff_mem_ready) begin
                        issue   = 1'b1;
                        wr_byte = mark_byte;
                        if (mark_idx == 3'd7) begin
                            w_state_n = W_IDLE;
                        end else begin
                            mark_idx_n = mark_idx + 3'd1;
                        end
                    end
                end
                W_DATA: begin
                    if (buff_mem_ready) begin
                        issue     = 1'b1;
                        pop       = 1'b1;
                        wr_byte   = fifo_mem[rd_ptr];
                        w_state_n = W_IDLE;
                    end
                end
                default: w_state_n = W_IDLE;
            endcase
        end
    end

    // Buffer port: strobe for one clk with data and address held, then step
    // the address on the clock after the strobe.
    always_ff @(posedge clk) begin
        if (clear) begin
            ram_wr <= 1'b0;
            ram_do <= '0;
            ram_a  <= '0;
        end else begin
            ram_wr <= issue;
            if (issue) begin
                ram_do <= wr_byte;
            end
            if (ram_wr) begin
                ram_a <= ram_a + 27'd1;
            end
        end
    end

    assign rec_len = ram_a;

endmodule

// File: tb/tb_cas_recorder.sv
// tb_cas_recorder
//   Scoreboard bench for cas_recorder. Tape timing is scaled down (short
//   cycle 8 ticks, long cycle 16 ticks, gap 64, header minimum 16 shorts)
//   so a whole session fits in a short run; ce_5m3 fires every 2nd clock.
//   The stimulus side describes blocks as headers and bytes, the reference
//   model turns that into the .CAS byte stream the buffer should receive,
//   and a monitor pops and compares on every ram_wr strobe.

module tb_cas_recorder;

    localparam int SHORT_MAX = 12;
    localparam int GAP_TICKS = 64;
    localparam int HDR_MIN   = 16;
    localparam int T_SHORT   = 8;
    localparam int T_LONG    = 16;
    localparam int HDR_OK    = 20;
    localparam int HDR_BAD   = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_5m3 = 1'b0;
    logic        motor = 1'b0;
    logic        cas_in = 1'b0;
    logic        rewind = 1'b0;
    logic        buff_mem_ready = 1'b0;
    logic [26:0] ram_a;
    logic [7:0]  ram_do;
    logic        ram_wr;
    logic [26:0] rec_len;
    logic        frame_err;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;

    int          cyc_q[$];
    logic [34:0] exp_q[$];
    int          model_addr = 0;
    bit          exp_frame_err = 1'b0;
    bit          exp_overflow = 1'b0;
    bit          stall = 1'b0;
    int          stall_bytes = 0;
    int          ready_mode = 0;
    bit          prev_wr = 1'b0;
    bit          ready_seen = 1'b0;
    logic [7:0]  marker [8] = '{8'h1F, 8'hA6, 8'hDE, 8'hBA, 8'hCC, 8'h13, 8'h7D, 8'h74};

    cas_recorder #(
        .SHORT_MAX(SHORT_MAX),
        .GAP_TICKS(GAP_TICKS),
        .HDR_MIN(HDR_MIN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ce_5m3(ce_5m3),
        .motor(motor),
        .cas_in(cas_in),
        .rewind(rewind),
        .ram_a(ram_a),
        .ram_do(ram_do),
        .ram_wr(ram_wr),
        .buff_mem_ready(buff_mem_ready),
        .rec_len(rec_len),
        .frame_err(frame_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Tick enable at half the clock rate.
    initial begin
        forever begin
            @(posedge clk);
            #1 ce_5m3 = ~ce_5m3;
        end
    end

    // Buffer readiness: random, forced high, or stalled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall || ready_mode == 2) begin
                buff_mem_ready = 1'b0;
            end else if (ready_mode == 1) begin
                buff_mem_ready = 1'b1;
            end else begin
                buff_mem_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: every strobe must match the next expected byte, be a single
    // clock wide, and follow a clock where the buffer was ready.
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (ram_wr) begin
                vectors++;
                if (prev_wr) begin
                    miscompares++;
                    $display("[TB] FAIL strobe_width: ram_wr high 2 clks at addr %0d, required 1 clk", ram_a);
                end
                vectors++;
                if (!ready_seen) begin
                    miscompares++;
                    $display("[TB] FAIL strobe_ready: write at addr %0d with buff_mem_ready=0, required 1", ram_a);
                end
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_write: addr %0d data %h, required no write", ram_a, ram_do);
                end else begin
                    e = exp_q.pop_front();
                    if ({ram_a, ram_do} !== e) begin
                        miscompares++;
                        $display("[TB] FAIL write: got addr %0d data %h, required addr %0d data %h",
                                 ram_a, ram_do, e[34:8], e[7:0]);
                    end
                end
            end
            prev_wr    = ram_wr;
            ready_seen = buff_mem_ready;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitTicks(input int n);
        repeat (2 * n) @(negedge clk);
    endtask

    task automatic playCycle(input int ticks);
        cas_in = 1'b1;
        waitTicks(ticks / 2);
        cas_in = 1'b0;
        waitTicks(ticks - ticks / 2);
    endtask

    // Plays the queued cycles; closing a block adds the rising edge that
    // terminates the last cycle, then a silence longer than the gap.
    task automatic applyStimulus(input bit close_block);
        foreach (cyc_q[i]) playCycle(cyc_q[i]);
        cyc_q.delete();
        if (close_block) begin
            cas_in = 1'b1;
            waitTicks(4);
            cas_in = 1'b0;
            waitTicks(GAP_TICKS + 16);
        end
    endtask

    task automatic expectWrite(input logic [7:0] d);
        exp_q.push_back({27'(model_addr), d});
        model_addr++;
    endtask

    // Reference: a header becomes zero padding to the next 8-byte boundary
    // followed by the marker.
    task automatic modelHeader();
        while (model_addr % 8 != 0) expectWrite(8'h00);
        for (int i = 0; i < 8; i++) expectWrite(marker[i]);
    endtask

    // Reference: while the buffer is stalled only four bytes fit.
    task automatic modelByte(input logic [7:0] b);
        if (stall && stall_bytes >= 4) begin
            exp_overflow = 1'b1;
        end else begin
            expectWrite(b);
        end
        if (stall) stall_bytes++;
    endtask

    task automatic addHeader(input int n, input bit valid);
        repeat (n) cyc_q.push_back(T_SHORT);
        if (valid) modelHeader();
    endtask

    task automatic addBits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (b[i]) begin
                cyc_q.push_back(T_SHORT);
                cyc_q.push_back(T_SHORT);
            end else begin
                cyc_q.push_back(T_LONG);
            end
        end
    endtask

    task automatic addByte(input logic [7:0] b);
        cyc_q.push_back(T_LONG);
        addBits(b, 8);
        repeat (4) cyc_q.push_back(T_SHORT);
        modelByte(b);
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain_%s: %0d writes still missing, required 0", tag, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        vectors++;
        if (rec_len !== 27'(model_addr)) begin
            miscompares++;
            $display("[TB] FAIL %s_rec_len: got %0d, required %0d", tag, rec_len, model_addr);
        end
        vectors++;
        if (frame_err !== exp_frame_err) begin
            miscompares++;
            $display("[TB] FAIL %s_frame_err: got %0b, required %0b", tag, frame_err, exp_frame_err);
        end
        vectors++;
        if (overflow !== exp_overflow) begin
            miscompares++;
            $display("[TB] FAIL %s_overflow: got %0b, required %0b", tag, overflow, exp_overflow);
        end
    endtask

    task automatic doRewind();
        rewind = 1'b1;
        repeat (3) @(negedge clk);
        rewind = 1'b0;
        exp_q.delete();
        model_addr    = 0;
        exp_frame_err = 1'b0;
        exp_overflow  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int nb;
        logic [7:0] b;

        $display("[TB] cas_recorder scoreboard bench start");
        repeat (4) @(negedge clk);
        reset = 1'b0;
        motor = 1'b1;
        @(negedge clk);
        vectors++;
        if (ram_wr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ram_wr: got %0b, required 0", ram_wr);
        end
        vectors++;
        if (ram_do !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_ram_do: got %h, required 00", ram_do);
        end
        checkOutput("reset");

        // Header tone and one byte with the buffer always ready.
        ready_mode = 1;
        addHeader(HDR_OK, 1'b1);
        addByte(8'h5A);
        applyStimulus(1'b1);
        waitDrain("hdr_5a");
        checkOutput("hdr_5a");
        ready_mode = 0;

        // Three bytes, then a second header that needs padding.
        doRewind();
        addHeader(HDR_OK, 1'b1);
        for (int i = 0; i < 3; i++) addByte(8'($urandom));
        applyStimulus(1'b1);
        addHeader(HDR_OK, 1'b1);
        addByte(8'hFF);
        applyStimulus(1'b1);
        waitDrain("pad_ff");
        checkOutput("pad_ff");

        // Too-short header rejected by a long cycle, then a proper one.
        addHeader(HDR_BAD, 1'b0);
        cyc_q.push_back(T_LONG);
        addHeader(HDR_OK, 1'b1);
        addByte(8'($urandom));
        applyStimulus(1'b1);
        waitDrain("short_hdr");
        checkOutput("short_hdr");

        // Short-then-long inside bit 3: byte lost, frame_err set.
        b = 8'($urandom);
        addHeader(HDR_OK, 1'b1);
        cyc_q.push_back(T_LONG);
        addBits(b, 3);
        cyc_q.push_back(T_SHORT);
        cyc_q.push_back(T_LONG);
        exp_frame_err = 1'b1;
        applyStimulus(1'b1);
        addHeader(HDR_OK, 1'b1);
        addByte(8'($urandom));
        applyStimulus(1'b1);
        waitDrain("frame_err");
        checkOutput("frame_err");

        // Buffer stalled while five bytes arrive.
        stall = 1'b1;
        stall_bytes = 0;
        addHeader(HDR_OK, 1'b1);
        for (int i = 0; i < 5; i++) addByte(8'($urandom));
        applyStimulus(1'b1);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stall_overflow: got %0b, required 1", overflow);
        end
        stall = 1'b0;
        waitDrain("overflow");
        checkOutput("overflow");

        // Rewind in the middle of a byte.
        addHeader(HDR_OK, 1'b1);
        cyc_q.push_back(T_LONG);
        addBits(8'($urandom), 3);
        applyStimulus(1'b0);
        waitDrain("pre_rewind");
        doRewind();
        checkOutput("rewind");
        waitTicks(GAP_TICKS + 16);
        checkOutput("rewind_gap");

        // Motor dropped in the middle of a byte, then a clean block.
        addHeader(HDR_OK, 1'b1);
        cyc_q.push_back(T_LONG);
        addBits(8'($urandom), 4);
        applyStimulus(1'b0);
        waitDrain("pre_motor");
        motor = 1'b0;
        waitTicks(10);
        motor = 1'b1;
        waitTicks(GAP_TICKS + 16);
        checkOutput("motor_drop");
        addHeader(HDR_OK, 1'b1);
        addByte(8'($urandom));
        applyStimulus(1'b1);
        waitDrain("motor_recover");
        checkOutput("motor_recover");

        // Random blocks.
        for (int k = 0; k < 4; k++) begin
            addHeader(HDR_OK, 1'b1);
            nb = $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) addByte(8'($urandom));
            applyStimulus(1'b1);
            waitDrain("random");
            checkOutput("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
